// File: rtl/collision_lives.sv
`default_nettype none
// ============================================================================
// Module   : collision_lives
// Purpose  : Per-tick bird/pipe collision check in the bird's column.
//            Counts cleared pipes (saturating), tracks lives with a post-hit
//            invulnerability window, and flags game over.
// Revision : 1.0 - initial parametrised multi-life version
// ============================================================================
module collision_lives #(
  parameter  int ROWS      = 16,
  parameter  int SCORE_W   = 10,
  parameter  int LIVES     = 3,
  parameter  int GRACE     = 4,
  parameter  bit EDGE_KILL = 1'b1,
  localparam int LW        = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               restart,
  input  logic [ROWS-1:0]    bird,
  input  logic [ROWS-1:0]    pipe,
  output logic [SCORE_W-1:0] score,
  output logic [LW-1:0]      lives,
  output logic               gameover,
  output logic               hit,
  output logic               invuln
);

  // Grace counter needs at least one bit even when the window is disabled.
  localparam int GW = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

  localparam logic [GW-1:0]      C_GRACE     = GW'(GRACE);
  localparam logic [LW-1:0]      C_LIVES     = LW'(LIVES);
  localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_GRACE = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SCORE_W-1:0] r_score,     w_score_nxt;
  logic [LW-1:0]      r_lives,     w_lives_nxt;
  logic [GW-1:0]      r_grace_cnt, w_grace_nxt;
  logic               r_pipe_prev, w_pipe_prev_nxt;
  logic               r_taint,     w_taint_nxt;
  logic               r_hit,       w_hit_nxt;
  logic               r_gameover;
  logic               r_invuln;

  logic w_hit_raw;
  logic w_pipe_now;
  logic w_exit;

  // A hit is any overlap, or the bird being off-screen when edge-kill is on.
  assign w_hit_raw  = (|(bird & pipe)) | (EDGE_KILL & ~(|bird));
  assign w_pipe_now = |pipe;
  // Falling edge of pipe presence across ticks means the bird cleared a pipe.
  assign w_exit     = tick & r_pipe_prev & ~w_pipe_now;

  // State and datapath registers; restart and reset load identical values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_PLAY;
      r_score     <= '0;
      r_lives     <= C_LIVES;
      r_grace_cnt <= '0;
      r_pipe_prev <= 1'b0;
      r_taint     <= 1'b0;
      r_hit       <= 1'b0;
      r_gameover  <= 1'b0;
      r_invuln    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_grace_cnt <= w_grace_nxt;
      r_pipe_prev <= w_pipe_prev_nxt;
      r_taint     <= w_taint_nxt;
      r_hit       <= w_hit_nxt;
      r_gameover  <= (w_state_nxt == ST_OVER);
      r_invuln    <= (w_state_nxt == ST_GRACE);
    end
  end

  // Next-state and next-value logic; OVER holds everything by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_score_nxt     = r_score;
    w_lives_nxt     = r_lives;
    w_grace_nxt     = r_grace_cnt;
    w_pipe_prev_nxt = r_pipe_prev;
    w_taint_nxt     = r_taint;
    w_hit_nxt       = 1'b0;

    if (restart) begin
      w_state_nxt     = ST_PLAY;
      w_score_nxt     = '0;
      w_lives_nxt     = C_LIVES;
      w_grace_nxt     = '0;
      w_pipe_prev_nxt = 1'b0;
      w_taint_nxt     = 1'b0;
    end else if (tick && (r_state != ST_OVER)) begin
      w_pipe_prev_nxt = w_pipe_now;
      case (r_state)
        ST_PLAY: begin
          if (w_hit_raw) begin
            // Counted hit wins over a same-tick exit: no score this tick.
            w_hit_nxt   = 1'b1;
            w_lives_nxt = r_lives - LW'(1);
            w_taint_nxt = 1'b1;
            if (r_lives == LW'(1)) begin
              w_state_nxt = ST_OVER;
            end else if (GRACE > 0) begin
              w_state_nxt = ST_GRACE;
              w_grace_nxt = C_GRACE;
            end
          end else if (w_exit && !r_taint && (r_score != C_SCORE_MAX)) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
        end
        ST_GRACE: begin
          // Collisions are ignored here, but clean exits still score.
          w_grace_nxt = r_grace_cnt - GW'(1);
          if (r_grace_cnt == GW'(1)) begin
            w_state_nxt = ST_PLAY;
          end
          if (w_exit && !r_taint && (r_score != C_SCORE_MAX)) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
        end
        default: ;
      endcase
      // Any exit ends the pipe, so the taint from a hit inside it is dropped.
      if (w_exit) begin
        w_taint_nxt = 1'b0;
      end
    end
  end

  assign score    = r_score;
  assign lives    = r_lives;
  assign gameover = r_gameover;
  assign hit      = r_hit;
  assign invuln   = r_invuln;

endmodule
`default_nettype wire

// File: doc/collision_lives.md
Name: collision_lives

Overview:
- Parametrised successor to the single-hit collision/score block in the Flappy Bird datapath.
- Compares the bird column bitmap against the pipe column bitmap at the bird's x-position once per game tick.
- Counts pipes cleared, with saturation, and supports multiple lives with a post-hit invulnerability window and an optional edge-kill mode.
- Sits between the playfield shift logic and the score/LED display; gameover feeds the top-level game FSM.

Parameters:
- ROWS, 16, playfield height; width of bird and pipe bitmaps.
- SCORE_W, 10, score counter width; saturates at 2^SCORE_W-1.
- LIVES, 3, lives at reset/restart; must be 1 or more.
- GRACE, 4, number of ticks after a non-fatal hit during which collisions are ignored; 0 allowed.
- EDGE_KILL, 1, when 1, bird==0 (bird off-screen) counts as a hit.
- LW, $clog2(LIVES+1), width of the lives output (derived, not overridden).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high; returns all state to reset values.
- tick, in, 1, one-cycle game-step strobe; evaluation occurs only on cycles with tick=1.
- restart, in, 1, synchronous; starts a new game in any state.
- bird, in, ROWS, one-hot bird row in the collision column (0 = off-screen).
- pipe, in, ROWS, occupied pipe rows in the collision column (0 = no pipe).
- score, out, SCORE_W, pipes cleared.
- lives, out, LW, lives remaining.
- gameover, out, 1, high while in OVER.
- hit, out, 1, one-cycle pulse on each counted hit.
- invuln, out, 1, high while in GRACE.

Behaviour:
- Reset values: score=0, lives=LIVES, gameover=0, hit=0, invuln=0; state=PLAY; pipe_prev=0, taint=0, grace_cnt=0.
- All outputs are registered and reflect a tick on the clock edge where tick=1 is sampled, i.e. one cycle of latency.
- hit_raw = |(bird & pipe), OR (EDGE_KILL and bird==0).
- pipe_now = |pipe. pipe_prev is updated with pipe_now on every tick in PLAY and GRACE.
- exit = tick and pipe_prev and !pipe_now.
- States:
  - PLAY: on a tick with hit_raw, the hit is counted: hit pulses for 1 cycle, lives decrements, taint=1.
    - If lives was 1, go to OVER: lives=0, gameover=1.
    - Otherwise go to GRACE with grace_cnt=GRACE, or stay in PLAY if GRACE=0.
  - GRACE: invuln=1. hit_raw is ignored and does not set taint. Each tick decrements grace_cnt; the tick that takes grace_cnt from 1 to 0 returns to PLAY on that edge. Exactly GRACE ticks are immune; the next tick is evaluated normally.
  - OVER: all registers frozen and tick ignored. gameover stays 1 until reset or restart.
- Scoring: on exit in PLAY or GRACE with taint=0, score+1, saturating at max (no wrap). On any exit, taint is cleared.
- Simultaneous counted hit and exit (only possible through edge-kill): the hit has priority; no score that tick, and taint is cleared by the exit.
- restart (any state, tick irrelevant): next edge loads the reset values. restart has priority over tick.
- Reset asserted mid-game: immediate clear; no hit pulse is generated.
- Inputs are not required to be stable between ticks; they are sampled only on tick cycles.

Test Plan:
- Clean pass, defaults, EDGE_KILL=0: reset, then ticks with bird=16'h8000 and pipe=16'h7FFF for 20 ticks, then pipe=0 for 1 tick -> score=1, lives=3, hit never asserted, gameover=0.
- Hit and grace, GRACE=2: bird=16'h8000, pipe=16'hFFFF for 4 ticks -> hit on the first tick only, lives=2, invuln high for ticks 2-3, second hit on tick 4, lives=1. Then pipe=0 for 1 tick -> score unchanged at 0 (tainted).
- Final life: LIVES=1, bird=16'h0001, pipe=16'h0001, one tick -> gameover=1, lives=0. Further ticks with exits -> score and lives unchanged. Then restart -> score=0, lives=1, gameover=0 on the next edge.
- Edge kill: EDGE_KILL=1, bird=0, pipe=0, one tick -> hit=1, lives=2. With EDGE_KILL=0, same stimulus -> no hit.
- Saturation: SCORE_W=3, 9 clean pipe passes (pipe 16'h00FF for 1 tick then 0 for 1 tick, bird=16'h8000) -> score goes 1..7 and stays 7.
- Async reset mid-grace: assert reset between clock edges while invuln=1 -> outputs clear immediately without waiting for a clock edge (lives=3, invuln=0, score=0). Deassert reset, then a hit tick -> normal hit behaviour.
